// File: rtl/mode_counter.sv
// rtl/mode_counter.sv - up/down step counter with one-shot and periodic modes
module mode_counter #(
   parameter int WIDTH      = 20,
   parameter int STEP_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  en,
   input  logic                  periodic,
   input  logic                  down,
   input  logic [WIDTH-1:0]      limit,
   input  logic [STEP_WIDTH-1:0] step,
   output logic [WIDTH-1:0]      count,
   output logic                  tc,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                state;
   logic [WIDTH-1:0]      lim_q;
   logic [STEP_WIDTH-1:0] step_q;
   logic                  per_q;
   logic                  down_q;

   logic [WIDTH:0]        step_eff;
   logic [WIDTH:0]        sum_up;
   logic                  term;

   // Comparisons run at WIDTH+1 bits so count+step can never wrap.
   always_comb begin
      step_eff = '0;
      step_eff[STEP_WIDTH-1:0] = step_q;
      if (step_q == '0) step_eff = {{WIDTH{1'b0}}, 1'b1};
      sum_up = {1'b0, count} + step_eff;
      term   = down_q ? ({1'b0, count} <= step_eff) : (sum_up >= {1'b0, lim_q});
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         count  <= '0;
         tc     <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         lim_q  <= '0;
         step_q <= '0;
         per_q  <= 1'b0;
         down_q <= 1'b0;
      end else begin
         tc <= 1'b0;
         if (stop) begin
            state <= IDLE;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
         end else if (start) begin
            lim_q  <= limit;
            step_q <= step;
            per_q  <= periodic;
            down_q <= down;
            count  <= down ? limit : '0;
            state  <= RUN;
            busy   <= 1'b1;
            done   <= 1'b0;
         end else if (state == RUN && en) begin
            if (term) begin
               tc <= 1'b1;
               if (per_q) begin
                  count <= down_q ? lim_q : '0;
               end else begin
                  count <= down_q ? '0 : lim_q;
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end else begin
               count <= down_q ? (count - step_eff[WIDTH-1:0]) : sum_up[WIDTH-1:0];
            end
         end
      end
   end

endmodule

// File: tb/tb_mode_counter.sv
// tb/tb_mode_counter.sv - directed and random checks of mode_counter against a period model
module tb_mode_counter;

   localparam int WIDTH = 20;
   localparam int SW    = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start, stop, en, periodic, down;
   logic [WIDTH-1:0] limit;
   logic [SW-1:0]    step;
   logic [WIDTH-1:0] count;
   logic             tc, busy, done;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference: position k inside a period of n = max(1, ceil(L/s)) advances.
   int     m_state;
   longint m_L, m_s, m_k, m_count;
   bit     m_per, m_down, m_tc;

   mode_counter #(.WIDTH(WIDTH), .STEP_WIDTH(SW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .en(en),
      .periodic(periodic), .down(down), .limit(limit), .step(step),
      .count(count), .tc(tc), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_state = 0; m_count = 0; m_tc = 0; m_k = 0;
      m_L = 0; m_s = 1; m_per = 0; m_down = 0;
   endtask

   task automatic model_step();
      longint n;
      m_tc = 0;
      if (!rst_n) begin
         model_reset();
      end else if (stop) begin
         m_state = 0; m_count = 0;
      end else if (start) begin
         m_L = limit; m_s = (step == 0) ? 1 : step;
         m_per = periodic; m_down = down; m_k = 0;
         m_state = 1; m_count = down ? m_L : 0;
      end else if (m_state == 1 && en) begin
         n = (m_L == 0) ? 1 : (m_L + m_s - 1) / m_s;
         m_k++;
         if (m_k >= n) begin
            m_tc = 1;
            if (m_per) begin
               m_k = 0; m_count = m_down ? m_L : 0;
            end else begin
               m_state = 2; m_count = m_down ? 0 : m_L;
            end
         end else begin
            m_count = m_down ? m_L - m_k * m_s : m_k * m_s;
         end
      end
   endtask

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
         else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
         end
   endtask

   task automatic check_all();
      logic [WIDTH-1:0] exp_count;
      exp_count = m_count[WIDTH-1:0];
      check("count", 32'(count), 32'(exp_count));
      check("tc",    32'(tc),    32'(m_tc));
      check("busy",  32'(busy),  32'(m_state == 1));
      check("done",  32'(done),  32'(m_state == 2));
   endtask

   task automatic cycle(input bit st, input bit sp, input bit e);
      start = st; stop = sp; en = e;
      @(posedge clk);
      model_step();
      #1;
      check_all();
      start = 0; stop = 0;
   endtask

   task automatic cfg(input int l, input int s, input bit p, input bit d);
      limit = WIDTH'(l); step = SW'(s); periodic = p; down = d;
   endtask

   initial begin
      rst_n = 0; start = 0; stop = 0; en = 0;
      cfg(0, 0, 0, 0);
      model_reset();
      #1;
      check_all();
      repeat (2) @(posedge clk);
      #1 rst_n = 1;

      // IDLE ignores en
      repeat (3) cycle(0, 0, 1);

      // up periodic 0,1,2,3,0..
      cfg(4, 1, 1, 0); cycle(1, 0, 0);
      repeat (10) cycle(0, 0, 1);

      // up one-shot 0,3,6,9,10 then hold
      cfg(10, 3, 0, 0); cycle(1, 0, 0);
      repeat (6) cycle(0, 0, 1);
      check("oneshot_end", 32'(count), 32'd10);

      // down periodic from DONE, then step=0 as step=1
      cfg(5, 2, 1, 1); cycle(1, 0, 0);
      repeat (7) cycle(0, 0, 1);
      cfg(3, 0, 1, 1); cycle(1, 0, 0);
      repeat (5) cycle(0, 0, 1);

      // start+stop together goes to IDLE
      cfg(8, 1, 1, 0); cycle(1, 0, 0);
      repeat (3) cycle(0, 0, 1);
      cycle(1, 1, 1);
      check("start_stop_idle", 32'(count), 32'd0);
      // start on the terminal cycle restarts without tc
      cycle(1, 0, 0);
      repeat (7) cycle(0, 0, 1);
      cycle(1, 0, 1);
      check("restart_no_tc", 32'(tc), 32'd0);
      // config change mid-RUN ignored
      cfg(4, 1, 1, 0); cycle(1, 0, 0);
      repeat (2) cycle(0, 0, 1);
      cfg(2, 3, 0, 1);
      repeat (6) cycle(0, 0, 1);

      // gated en, limit 0 periodic / one-shot, stop from DONE
      cfg(7, 1, 0, 0); cycle(1, 0, 0);
      cycle(0, 0, 1); cycle(0, 0, 0); cycle(0, 0, 1); cycle(0, 0, 0); cycle(0, 0, 1);
      cfg(0, 2, 1, 0); cycle(1, 0, 0);
      repeat (4) cycle(0, 0, 1);
      cfg(0, 1, 0, 0); cycle(1, 0, 0);
      repeat (2) cycle(0, 0, 1);
      cfg(0, 1, 0, 1); cycle(1, 0, 0);
      repeat (2) cycle(0, 0, 1);
      cycle(0, 1, 0);

      // async reset mid-RUN at count 5
      cfg(9, 1, 1, 0); cycle(1, 0, 0);
      repeat (5) cycle(0, 0, 1);
      check("pre_reset_count", 32'(count), 32'd5);
      rst_n = 0; model_reset();
      #1;
      check_all();
      cycle(0, 0, 1);
      #2 rst_n = 1;
      repeat (3) cycle(0, 0, 1);
      cycle(1, 0, 0);
      repeat (3) cycle(0, 0, 1);

      // random stimulus
      for (int i = 0; i < 1500; i++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r == 0)      limit = '0;
         else if (r < 8)  limit = WIDTH'($urandom_range(1, 40));
         else             limit = WIDTH'((1 << WIDTH) - 1 - $urandom_range(0, 30));
         step = SW'($urandom_range(0, 15));
         periodic = 1'($urandom);
         down = 1'($urandom);
         cycle($urandom_range(0, 19) == 0, $urandom_range(0, 59) == 0, $urandom_range(0, 9) < 7);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mode_counter.md
MODE_COUNTER -- requirements
Module: mode_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 20, giving the counter, limit and count-output width in bits.
REQ-002 The block SHALL have parameter STEP_WIDTH, default 4, giving the step input width in bits.
REQ-003 The block SHALL have these ports, one per line (name  direction  width  meaning):
  clk  input  1  clock, rising edge
  rst_n  input  1  reset, asynchronous, active-low
  start  input  1  single-cycle pulse; latches config and (re)starts counting
  stop  input  1  synchronous abort to IDLE
  en  input  1  advance qualifier; one step per cycle while high in RUN
  periodic  input  1  0 = one-shot, 1 = periodic reload
  down  input  1  0 = count up from 0, 1 = count down from limit
  limit  input  WIDTH  terminal value
  step  input  STEP_WIDTH  increment per advance; 0 is treated as 1
  count  output  WIDTH  current count, registered
  tc  output  1  terminal-count pulse, registered, one cycle
  busy  output  1  high in RUN
  done  output  1  high in DONE (one-shot completed)

Function
REQ-004 The block SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-005 On start, the block SHALL latch limit, step, periodic and down into shadow registers; changes on those inputs at any other time SHALL be ignored.
REQ-006 On start, count SHALL load the start value (0 if down=0, latched limit if down=1), state SHALL go to RUN, and tc SHALL stay low in the following cycle.
REQ-007 In RUN with en=1, an advance SHALL be terminal when count+step_eff >= limit (up) or count <= step_eff (down), compared at WIDTH+1 bits with no overflow.
REQ-008 A non-terminal advance SHALL update count to count+step_eff (up) or count-step_eff (down).
REQ-009 A terminal advance SHALL assert tc high for exactly the next cycle.
REQ-010 A terminal advance in periodic mode SHALL reload count to the start value and remain in RUN, giving a period of ceil(limit/step_eff) en-cycles (minimum 1).
REQ-011 A terminal advance in one-shot mode SHALL set count to the end value (limit if up, 0 if down) and go to DONE.
REQ-012 In RUN with en=0, count and state SHALL hold.
REQ-013 In DONE, count SHALL hold, done=1, en SHALL be ignored, and start SHALL restart per REQ-006.
REQ-014 In IDLE, count SHALL be 0 and en SHALL be ignored.
REQ-015 Input priority SHALL be stop > start > en. Stop in any state SHALL go to IDLE with count=0 and no tc. Start in RUN SHALL restart with no tc, even if that cycle's advance would have been terminal.
REQ-016 With latched limit=0, every advance SHALL be terminal: tc on each en cycle in periodic mode; immediate DONE in one-shot mode.
REQ-017 busy and done SHALL be registered decodes of the state, valid the cycle after the transition, and never high together.

Reset
REQ-018 While rst_n=0, the block SHALL hold state=IDLE, count=0, tc=0, busy=0, done=0 and all shadow registers at 0, asynchronously.
REQ-019 Reset asserted mid-RUN SHALL abort the count immediately with no tc.
REQ-020 After reset release, the block SHALL stay in IDLE until start.

Verification
REQ-021 Up periodic: limit=4, step=1, start, en=1 held -> count 0,1,2,3,0,1,...; tc one cycle after each 3->0 reload, period 4.
REQ-022 Up one-shot: limit=10, step=3 -> count 0,3,6,9,10; then done=1, busy=0, single tc; further en leaves count at 10.
REQ-023 Down periodic: limit=5, step=2 -> count 5,3,1,5,...; tc every 3 en-cycles. Step=0 with limit=3 -> behaves as step=1.
REQ-024 Priority: start and stop together mid-RUN -> IDLE, count=0. Start on the terminal cycle -> restart at 0, no tc. Change limit mid-RUN -> period unchanged.
REQ-025 Gated en and limit=0: en toggling 1,0,1 with limit=7 -> count advances only on en=1 cycles. Limit=0 periodic -> tc on every en cycle. Limit=0 one-shot -> DONE after the first en.
REQ-026 Reset: rst_n low mid-RUN at count=5 -> all outputs 0 immediately; no tc after release; start is required to resume.
